// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: shift-register scoreboard of in-flight writers behind
// decode, producing bypass selects, load-use/interlock stall, kill bubbles and stage valids.
module hazard_scoreboard #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_rs1_used,
    input  logic              d_rs2_used,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_wen,
    input  logic              d_is_load,
    input  logic              kill,
    output logic              stall,
    output logic [2:0]        fwd_sel_a,
    output logic [2:0]        fwd_sel_b,
    output logic [DEPTH-1:0]  stage_valid,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  kill_cnt
);

    // Entry k (1 = X ... DEPTH = W) lives at index k.
    logic [DEPTH:1]             valid_q, valid_d;
    logic [DEPTH:1]             wen_q, wen_d;
    logic [DEPTH:1]             load_q, load_d;
    logic [DEPTH:1][REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]           stall_cnt_q, kill_cnt_q;

    logic       haz_a, haz_b;
    logic [2:0] sel_a, sel_b;
    logic       accept;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        haz_a = 1'b0;
        haz_b = 1'b0;
        sel_a = 3'd0;
        sel_b = 3'd0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (d_rs1_used && valid_q[k] && wen_q[k] && (rd_q[k] != '0) && (rd_q[k] == d_rs1)) begin
                sel_a = 3'(k);
                haz_a = FWD_EN ? (load_q[k] && (k <= int'(LOAD_LAT))) : 1'b1;
            end
            if (d_rs2_used && valid_q[k] && wen_q[k] && (rd_q[k] != '0) && (rd_q[k] == d_rs2)) begin
                sel_b = 3'(k);
                haz_b = FWD_EN ? (load_q[k] && (k <= int'(LOAD_LAT))) : 1'b1;
            end
        end
    end

    assign stall     = d_valid && !kill && (haz_a || haz_b);
    assign fwd_sel_a = FWD_EN ? sel_a : 3'd0;
    assign fwd_sel_b = FWD_EN ? sel_b : 3'd0;
    assign accept    = !stall && !kill;

    always_comb begin
        valid_d = {valid_q[DEPTH-1:1], d_valid & accept};
        wen_d   = {wen_q[DEPTH-1:1], d_wen & accept};
        load_d  = {load_q[DEPTH-1:1], d_is_load & accept};
        rd_d    = {rd_q[DEPTH-1:1], d_rd & {REG_AW{accept}}};
        // The redirecting instruction's wrong-path successor is leaving entry 1 right now.
        if (kill) begin
            valid_d[2] = 1'b0;
            wen_d[2]   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            wen_q       <= '0;
            load_q      <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            wen_q       <= wen_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall);
            kill_cnt_q  <= kill_cnt_q + CNT_W'(kill);
        end
    end

    assign stage_valid = valid_q;
    assign wb_en       = valid_q[DEPTH] && wen_q[DEPTH] && (rd_q[DEPTH] != '0);
    assign wb_rd       = rd_q[DEPTH];
    assign stall_cnt   = stall_cnt_q;
    assign kill_cnt    = kill_cnt_q;

endmodule
